bomb_game_ctrl: RTL

Game-flow controller sitting directly upstream of the 8×8 bomb dot-matrix display stage. It debounces the player's master switch, arm button and wire-cut switches, and picks a secret "correct wire" when the player arms the bomb. It drives the display's `start`, `BombSwitch` and `rst` inputs and consumes the display's `fail` output. It resolves every round to DEFUSED or EXPLODED.

---
 rtl/bomb_pkg.sv | 17 +
 rtl/bomb_game_ctrl_debounce.sv | 46 ++++
 rtl/bomb_game_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bomb_pkg.sv
// Shared types and default parameters for the bomb game-flow controller.
package bomb_pkg;

  typedef enum logic [2:0] {
    S_OFF,
    S_IDLE,
    S_ARMING,
    S_ARMED,
    S_DEFUSED,
    S_EXPLODED
  } game_state_t;

  localparam int NWIRES_DEF       = 4;
  localparam int DEB_CYCLES_DEF   = 16;
  localparam int FLASH_CYCLES_DEF = 2800;

endpackage

// File: rtl/bomb_game_ctrl_debounce.sv
// Multi-bit 2-FF synchronizer followed by an independent debounce counter per bit.
module debounce #(
  parameter int W          = 1,
  parameter int DEB_CYCLES = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_deb
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [W-1:0]         r_sync1;
  logic [W-1:0]         r_sync2;
  logic [W-1:0]         r_deb;
  logic [W-1:0][CW-1:0] r_cnt;

  // Synchronize, then flip a bit only after DEB_CYCLES consecutive disagreeing cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < W; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_cnt[i] == CW'(DEB_CYCLES - 1)) begin
            r_deb[i] <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/bomb_game_ctrl.sv
// Game-flow controller for the bomb dot-matrix display: conditions player inputs,
// picks the secret wire on arming and resolves each round to DEFUSED or EXPLODED.
module bomb_game_ctrl
  import bomb_pkg::*;
#(
  parameter int NWIRES       = NWIRES_DEF,
  parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
  parameter int FLASH_CYCLES = FLASH_CYCLES_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_power,
  input  logic                      i_arm_btn,
  input  logic [NWIRES-1:0]         i_wire_cut,
  input  logic                      i_fail_in,
  output logic                      o_start,
  output logic                      o_bomb_switch,
  output logic                      o_disp_rst,
  output logic                      o_defused,
  output logic                      o_exploded,
  output logic [$clog2(NWIRES)-1:0] o_target
);

  localparam int TW = $clog2(NWIRES);
  localparam int FW = $clog2(FLASH_CYCLES);

  game_state_t       r_state;
  game_state_t       w_state_nxt;
  logic [NWIRES+1:0] w_deb;
  logic              w_power_d;
  logic              w_arm_d;
  logic [NWIRES-1:0] w_cut_d;
  logic              r_arm_q;
  logic              r_arm_rise;
  logic [NWIRES-1:0] r_cut_q;
  logic [NWIRES-1:0] r_cut_rise;
  logic [TW-1:0]     r_sel_cnt;
  logic [TW-1:0]     r_target;
  logic [FW-1:0]     r_flash_cnt;
  logic              r_flash;
  logic [NWIRES-1:0] w_tgt_mask;

  debounce #(
    .W          (NWIRES + 2),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_raw ({i_power, i_arm_btn, i_wire_cut}),
    .o_deb (w_deb)
  );

  assign w_power_d  = w_deb[NWIRES+1];
  assign w_arm_d    = w_deb[NWIRES];
  assign w_cut_d    = w_deb[NWIRES-1:0];
  assign w_tgt_mask = NWIRES'(1) << r_target;

  // Registered rising-edge pulses; releases and reconnects produce nothing.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_arm_q    <= 1'b0;
      r_arm_rise <= 1'b0;
      r_cut_q    <= '0;
      r_cut_rise <= '0;
    end else begin
      r_arm_q    <= w_arm_d;
      r_arm_rise <= w_arm_d & ~r_arm_q;
      r_cut_q    <= w_cut_d;
      r_cut_rise <= w_cut_d & ~r_cut_q;
    end
  end

  // Free-running wire selector; whatever it holds during ARMING becomes the target.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sel_cnt <= '0;
      r_target  <= '0;
    end else begin
      r_sel_cnt <= (r_sel_cnt == TW'(NWIRES - 1)) ? '0 : r_sel_cnt + 1'b1;
      if (r_state == S_ARMING) r_target <= r_sel_cnt;
    end
  end

  // Blink generator: restarts lit on EXPLODED entry, toggles every FLASH_CYCLES.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_flash_cnt <= '0;
      r_flash     <= 1'b1;
    end else if (w_state_nxt == S_EXPLODED && r_state != S_EXPLODED) begin
      r_flash_cnt <= '0;
      r_flash     <= 1'b1;
    end else if (r_state == S_EXPLODED) begin
      if (r_flash_cnt == FW'(FLASH_CYCLES - 1)) begin
        r_flash_cnt <= '0;
        r_flash     <= ~r_flash;
      end else begin
        r_flash_cnt <= r_flash_cnt + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_OFF;
    else        r_state <= w_state_nxt;
  end

  // Next-state and output decode; losing power overrides everything.
  always_comb begin
    w_state_nxt   = r_state;
    o_start       = 1'b0;
    o_bomb_switch = 1'b0;
    o_disp_rst    = 1'b0;
    o_defused     = 1'b0;
    o_exploded    = 1'b0;

    if (!w_power_d) begin
      w_state_nxt = S_OFF;
    end else begin
      case (r_state)
        S_OFF:    w_state_nxt = S_IDLE;
        S_IDLE, S_DEFUSED, S_EXPLODED:
          if (r_arm_rise && w_cut_d == '0) w_state_nxt = S_ARMING;
        S_ARMING: w_state_nxt = S_ARMED;
        S_ARMED: begin
          if (i_fail_in)                          w_state_nxt = S_EXPLODED;
          else if (|(r_cut_rise & ~w_tgt_mask))   w_state_nxt = S_EXPLODED;
          else if (r_cut_rise[r_target])          w_state_nxt = S_DEFUSED;
        end
        default:  w_state_nxt = S_OFF;
      endcase
    end

    case (r_state)
      S_IDLE:     o_bomb_switch = 1'b1;
      S_ARMING: begin
        o_bomb_switch = 1'b1;
        o_disp_rst    = 1'b1;
      end
      S_ARMED: begin
        o_bomb_switch = 1'b1;
        o_start       = 1'b1;
      end
      S_DEFUSED: begin
        o_bomb_switch = 1'b1;
        o_defused     = 1'b1;
      end
      S_EXPLODED: begin
        o_exploded    = 1'b1;
        o_bomb_switch = r_flash;
      end
      default: ;
    endcase
  end

  assign o_target = r_target;

endmodule
